// File: rtl/scaler_pkg.sv
// scaler_pkg: shared constants, FSM states and helpers for the scaler parameter calculator.
// Optional build macro SCALER_PARAM_CALC_ROUND_EN selects round-half-up scale factors.
package scaler_pkg;
   localparam int SF_BITWIDTH      = 24;
   localparam int SF_FRAC_BITWIDTH = 20;
   localparam logic [SF_BITWIDTH-1:0] SF_ONE = 24'h10_0000;
   localparam logic [SF_BITWIDTH-1:0] SF_SAT = 24'hFF_FFFF;
   localparam int ERR_ZERO = 0;
   localparam int ERR_OVF  = 1;
`ifdef SCALER_PARAM_CALC_ROUND_EN
   localparam bit ROUND_EN = 1'b1;
`else
   localparam bit ROUND_EN = 1'b0;
`endif
   typedef enum logic [2:0] {ST_IDLE, ST_CHK, ST_DIV_H, ST_DIV_V, ST_DONE} state_t;
   function automatic int clog2(input int v);
      int r = 0;
      for (int i = 0; i < 31; i++) if ((1 << i) < v) r = i + 1;
      return r;
   endfunction
endpackage

// File: rtl/scaler_div_serial.sv
// scaler_div_serial: restoring serial divider computing (dividend << FRAC_W) / divisor,
// one quotient bit per cycle; with ROUND an extra half-LSB bit is produced and the
// result is rounded half-up with saturation. The caller must guarantee the true quotient
// fits in Q_W bits, so the leading integer iterations are folded into the initial remainder.
module scaler_div_serial #(
   parameter int DVD_W  = 12,
   parameter int DVS_W  = 12,
   parameter int Q_W    = 24,
   parameter int FRAC_W = 20,
   parameter bit ROUND  = 1'b0
) (
   input  logic             i_clk,
   input  logic             i_rst_n,
   input  logic             i_start,
   input  logic [DVD_W-1:0] i_dividend,
   input  logic [DVS_W-1:0] i_divisor,
   output logic [Q_W-1:0]   o_quot,
   output logic             o_done
);
   localparam int N     = Q_W + int'(ROUND);
   localparam int INT_W = Q_W - FRAC_W;
   localparam int CNT_W = $clog2(N + 1);
   logic [DVS_W-1:0] r_rem;
   logic [DVS_W-1:0] r_dvs;
   logic [N-1:0]     r_bits;
   logic [N-1:0]     r_q;
   logic [CNT_W-1:0] r_cnt;
   logic [DVS_W:0]   w_trial;
   logic [DVS_W:0]   w_diff;
   logic             w_qbit;
   logic [N-1:0]     w_qfull;
   assign w_trial = {r_rem, r_bits[N-1]};
   assign w_diff  = w_trial - {1'b0, r_dvs};
   assign w_qbit  = (w_trial >= {1'b0, r_dvs});
   assign w_qfull = {r_q[N-2:0], w_qbit};
   assign o_done  = (r_cnt == CNT_W'(1));
   generate
      if (ROUND) begin : g_rnd
         assign o_quot = (&w_qfull[N-1:1]) ? '1 : w_qfull[N-1:1] + Q_W'(w_qfull[0]);
      end else begin : g_trn
         assign o_quot = w_qfull;
      end
   endgenerate
   // load operands on start, otherwise shift in one quotient bit per cycle while counting down
   always_ff @(posedge i_clk or negedge i_rst_n)
      if (!i_rst_n) begin
         r_rem  <= '0;
         r_dvs  <= '0;
         r_bits <= '0;
         r_q    <= '0;
         r_cnt  <= '0;
      end else if (i_start) begin
         r_rem  <= DVS_W'(i_dividend >> INT_W);
         r_dvs  <= i_divisor;
         r_bits <= {i_dividend[INT_W-1:0], {(N-INT_W){1'b0}}};
         r_q    <= '0;
         r_cnt  <= CNT_W'(N);
      end else if (r_cnt != '0) begin
         r_rem  <= DVS_W'(w_qbit ? w_diff : w_trial);
         r_bits <= r_bits << 1;
         r_q    <= w_qfull;
         r_cnt  <= r_cnt - CNT_W'(1);
      end
endmodule

// File: rtl/scaler_param_calc.sv
// scaler_param_calc: latches source/destination sizes on start and computes scale mode and
// Q20 H/V scale factors with one time-shared serial divider (SCALER_PARAM_CALC_ROUND_EN via scaler_pkg).
module scaler_param_calc
   import scaler_pkg::*;
#(
   parameter int IMG_H_MAX      = 3840,
   parameter int IMG_V_MAX      = 2160,
   parameter int IMG_H_BITWIDTH = clog2(IMG_H_MAX),
   parameter int IMG_V_BITWIDTH = clog2(IMG_V_MAX)
) (
   input  logic                      core_clk,
   input  logic                      core_rst_n,
   input  logic                      start,
   input  logic [IMG_H_BITWIDTH-1:0] in_src_h,
   input  logic [IMG_V_BITWIDTH-1:0] in_src_v,
   input  logic [IMG_H_BITWIDTH-1:0] in_des_h,
   input  logic [IMG_V_BITWIDTH-1:0] in_des_v,
   output logic [IMG_H_BITWIDTH-1:0] arg_src_h,
   output logic [IMG_V_BITWIDTH-1:0] arg_src_v,
   output logic [IMG_H_BITWIDTH-1:0] arg_des_h,
   output logic [IMG_V_BITWIDTH-1:0] arg_des_v,
   output logic                      arg_mode,
   output logic [SF_BITWIDTH-1:0]    arg_hsf,
   output logic [SF_BITWIDTH-1:0]    arg_vsf,
   output logic                      busy,
   output logic                      done,
   output logic [1:0]                err
);
   localparam int DW    = (IMG_H_BITWIDTH > IMG_V_BITWIDTH) ? IMG_H_BITWIDTH : IMG_V_BITWIDTH;
   localparam int INT_W = SF_BITWIDTH - SF_FRAC_BITWIDTH;
   localparam int HC_W  = IMG_H_BITWIDTH + INT_W;
   localparam int VC_W  = IMG_V_BITWIDTH + INT_W;
   state_t                    r_state;
   logic [IMG_H_BITWIDTH-1:0] r_src_h, r_des_h;
   logic [IMG_V_BITWIDTH-1:0] r_src_v, r_des_v;
   logic [SF_BITWIDTH-1:0]    r_hq, r_vq;
   logic                      w_zh, w_zv, w_oh, w_ov;
   logic                      w_div_start, w_div_done;
   logic [DW-1:0]             w_dvd, w_dvs;
   logic [SF_BITWIDTH-1:0]    w_quot;
   // zero destination wins over overflow on the same axis; ratio >= 16 cannot fit Q20 in 24 bits
   assign w_zh = (r_des_h == '0);
   assign w_zv = (r_des_v == '0);
   assign w_oh = !w_zh && (HC_W'(r_src_h) >= (HC_W'(r_des_h) << INT_W));
   assign w_ov = !w_zv && (VC_W'(r_src_v) >= (VC_W'(r_des_v) << INT_W));
   assign w_div_start = (r_state == ST_CHK) || ((r_state == ST_DIV_H) && w_div_done);
   assign w_dvd = (r_state == ST_CHK) ? DW'(r_src_h) : DW'(r_src_v);
   assign w_dvs = (r_state == ST_CHK) ? DW'(r_des_h) : DW'(r_des_v);
   scaler_div_serial #(
      .DVD_W (DW),
      .DVS_W (DW),
      .Q_W   (SF_BITWIDTH),
      .FRAC_W(SF_FRAC_BITWIDTH),
      .ROUND (ROUND_EN)
   ) u_div (
      .i_clk     (core_clk),
      .i_rst_n   (core_rst_n),
      .i_start   (w_div_start),
      .i_dividend(w_dvd),
      .i_divisor (w_dvs),
      .o_quot    (w_quot),
      .o_done    (w_div_done)
   );
   // control FSM: latch, classify, divide H then V, then publish all results in one cycle
   always_ff @(posedge core_clk or negedge core_rst_n)
      if (!core_rst_n) begin
         r_state   <= ST_IDLE;
         r_src_h   <= '0;
         r_src_v   <= '0;
         r_des_h   <= '0;
         r_des_v   <= '0;
         r_hq      <= '0;
         r_vq      <= '0;
         arg_src_h <= '0;
         arg_src_v <= '0;
         arg_des_h <= '0;
         arg_des_v <= '0;
         arg_mode  <= 1'b0;
         arg_hsf   <= SF_ONE;
         arg_vsf   <= SF_ONE;
         busy      <= 1'b0;
         done      <= 1'b0;
         err       <= '0;
      end else begin
         done <= 1'b0;
         case (r_state)
            ST_IDLE: if (start) begin
               r_src_h <= in_src_h;
               r_src_v <= in_src_v;
               r_des_h <= in_des_h;
               r_des_v <= in_des_v;
               busy    <= 1'b1;
               r_state <= ST_CHK;
            end
            ST_CHK: r_state <= ST_DIV_H;
            ST_DIV_H: if (w_div_done) begin
               r_hq    <= w_quot;
               r_state <= ST_DIV_V;
            end
            ST_DIV_V: if (w_div_done) begin
               r_vq    <= w_quot;
               r_state <= ST_DONE;
            end
            ST_DONE: begin
               arg_src_h     <= r_src_h;
               arg_src_v     <= r_src_v;
               arg_des_h     <= r_des_h;
               arg_des_v     <= r_des_v;
               arg_mode      <= (r_des_h > r_src_h) || (r_des_v > r_src_v);
               arg_hsf       <= (w_zh || w_oh) ? SF_SAT : r_hq;
               arg_vsf       <= (w_zv || w_ov) ? SF_SAT : r_vq;
               err[ERR_ZERO] <= w_zh || w_zv;
               err[ERR_OVF]  <= w_oh || w_ov;
               done          <= 1'b1;
               busy          <= 1'b0;
               r_state       <= ST_IDLE;
            end
            default: r_state <= ST_IDLE;
         endcase
      end
endmodule

// File: tb/tb_scaler_param_calc.sv
// tb_scaler_param_calc: scoreboard bench; stimulus pushes hand-computed expectations, a monitor checks each done.
`timescale 1ns/1ps
module tb_scaler_param_calc;
   import scaler_pkg::*;
   localparam int LAT = ROUND_EN ? 52 : 50;
   logic        core_clk = 1'b0;
   logic        core_rst_n = 1'b0;
   logic        start = 1'b0;
   logic [11:0] in_src_h = '0, in_src_v = '0, in_des_h = '0, in_des_v = '0;
   logic [11:0] arg_src_h, arg_src_v, arg_des_h, arg_des_v;
   logic        arg_mode, busy, done;
   logic [23:0] arg_hsf, arg_vsf;
   logic [1:0]  err;
   int n_tests = 0;
   int n_fail = 0;
   typedef struct {
      logic [11:0] sh, sv, dh, dv;
      logic        m;
      logic [23:0] h, v;
      logic [1:0]  e;
      longint      t;
   } exp_t;
   exp_t sb[$];
   scaler_param_calc dut (
      .core_clk(core_clk), .core_rst_n(core_rst_n), .start(start),
      .in_src_h(in_src_h), .in_src_v(in_src_v), .in_des_h(in_des_h), .in_des_v(in_des_v),
      .arg_src_h(arg_src_h), .arg_src_v(arg_src_v), .arg_des_h(arg_des_h), .arg_des_v(arg_des_v),
      .arg_mode(arg_mode), .arg_hsf(arg_hsf), .arg_vsf(arg_vsf),
      .busy(busy), .done(done), .err(err)
   );
   always #5 core_clk = ~core_clk;
   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask
   task automatic issue(input logic [11:0] sh, sv, dh, dv, input logic m,
                        input logic [23:0] h, v, input logic [1:0] e);
      exp_t x;
      in_src_h = sh; in_src_v = sv; in_des_h = dh; in_des_v = dv;
      start = 1'b1;
      x.sh = sh; x.sv = sv; x.dh = dh; x.dv = dv; x.m = m; x.h = h; x.v = v; x.e = e;
      x.t = longint'($time) + 10 + LAT * 10;
      sb.push_back(x);
      @(negedge core_clk);
      start = 1'b0;
      in_src_h = 12'hABC; in_src_v = 12'h123; in_des_h = 12'h001; in_des_v = 12'hFFF;
   endtask
   task automatic drain();
      for (int i = 0; i < LAT + 20 && sb.size() != 0; i++) @(negedge core_clk);
      if (sb.size() != 0) begin
         n_tests++; n_fail++;
         $display("FAIL timeout: %0d results outstanding, required 0", sb.size());
         sb.delete();
      end
      @(negedge core_clk);
   endtask
   task automatic run(input logic [11:0] sh, sv, dh, dv, input logic m,
                      input logic [23:0] h, v, input logic [1:0] e);
      issue(sh, sv, dh, dv, m, h, v, e);
      drain();
   endtask
   // monitor: every done must match the oldest outstanding expectation, including its timing
   initial forever begin
      exp_t x;
      @(negedge core_clk);
      if (done) begin
         if (sb.size() == 0) begin
            n_tests++; n_fail++;
            $display("FAIL spurious_done: got done at %0t, required none", $time);
         end else begin
            x = sb.pop_front();
            chk("latency", 64'($time), 64'(x.t));
            chk("src_h", arg_src_h, x.sh);
            chk("src_v", arg_src_v, x.sv);
            chk("des_h", arg_des_h, x.dh);
            chk("des_v", arg_des_v, x.dv);
            chk("mode", arg_mode, x.m);
            chk("hsf", arg_hsf, x.h);
            chk("vsf", arg_vsf, x.v);
            chk("err", err, x.e);
            chk("busy_at_done", busy, 1'b0);
         end
      end
   end
   initial begin
      #200us;
      $display("FAIL watchdog: simulation did not finish, required finish");
      $fatal(1, "watchdog");
   end
   initial begin
      longint ts;
      int low;
      repeat (2) @(negedge core_clk);
      chk("rst_busy", busy, 1'b0);
      chk("rst_done", done, 1'b0);
      chk("rst_err", err, 2'b00);
      chk("rst_hsf", arg_hsf, 24'h10_0000);
      chk("rst_vsf", arg_vsf, 24'h10_0000);
      chk("rst_src_h", arg_src_h, 12'd0);
      chk("rst_mode", arg_mode, 1'b0);
      core_rst_n = 1'b1;
      @(negedge core_clk);
      run(12'd300, 12'd300, 12'd100, 12'd100, 1'b0, 24'h30_0000, 24'h30_0000, 2'b00);
      run(12'd200, 12'd100, 12'd300, 12'd200, 1'b1, ROUND_EN ? 24'h0A_AAAB : 24'h0A_AAAA, 24'h08_0000, 2'b00);
      run(12'd300, 12'd300, 12'd0, 12'd100, 1'b0, 24'hFF_FFFF, 24'h30_0000, 2'b01);
      run(12'd3840, 12'd2160, 12'd200, 12'd2160, 1'b0, 24'hFF_FFFF, 24'h10_0000, 2'b10);
      run(12'd1599, 12'd1600, 12'd100, 12'd100, 1'b0, 24'hFF_D70A, 24'hFF_FFFF, 2'b10);
      run(12'd300, 12'd300, 12'd0, 12'd0, 1'b0, 24'hFF_FFFF, 24'hFF_FFFF, 2'b01);
      run(12'd1, 12'd1, 12'd3840, 12'd2160, 1'b1, 24'h00_0111, 24'h00_01E5, 2'b00);
      run(12'd640, 12'd480, 12'd640, 12'd480, 1'b0, 24'h10_0000, 24'h10_0000, 2'b00);
      // second start mid-operation and during the DONE cycle are both ignored
      ts = longint'($time) + 5;
      issue(12'd300, 12'd300, 12'd100, 12'd100, 1'b0, 24'h30_0000, 24'h30_0000, 2'b00);
      low = 0;
      repeat (9) begin @(negedge core_clk); if (!busy) low++; end
      in_src_h = 12'd1; in_src_v = 12'd1; in_des_h = 12'd3840; in_des_v = 12'd2160;
      start = 1'b1;
      @(negedge core_clk);
      start = 1'b0;
      while (longint'($time) < ts + (LAT - 1) * 10 + 5) begin
         if (!busy) low++;
         @(negedge core_clk);
      end
      chk("busy_low_cycles", low, 0);
      chk("busy_in_done_state", busy, 1'b1);
      start = 1'b1;
      @(negedge core_clk);
      start = 1'b0;
      repeat (LAT + 5) @(negedge core_clk);
      chk("busy_after_ignored", busy, 1'b0);
      chk("outstanding", sb.size(), 0);
      // reset while dividing V: outputs revert at once and no done follows
      issue(12'd200, 12'd100, 12'd300, 12'd200, 1'b1, 24'h0, 24'h0, 2'b00);
      repeat (35) @(negedge core_clk);
      core_rst_n = 1'b0;
      sb.delete();
      #1;
      chk("mid_rst_busy", busy, 1'b0);
      chk("mid_rst_src_h", arg_src_h, 12'd0);
      chk("mid_rst_hsf", arg_hsf, 24'h10_0000);
      chk("mid_rst_mode", arg_mode, 1'b0);
      chk("mid_rst_err", err, 2'b00);
      repeat (2) @(negedge core_clk);
      core_rst_n = 1'b1;
      repeat (LAT + 10) @(negedge core_clk);
      chk("post_rst_busy", busy, 1'b0);
      run(12'd300, 12'd300, 12'd100, 12'd100, 1'b0, 24'h30_0000, 24'h30_0000, 2'b00);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
